// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter for a shared FIFO. Each grant has a burst lock of
// at most MAX_BURST accepted beats. Accepted words go to the FIFO in the same cycle.

module fifo_write_arbiter_lane #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  granted,
    input  logic                  own,
    input  logic                  fifo_full,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ready,
    output logic                  wr,
    output logic [DATA_WIDTH-1:0] data_out
);
    assign ready    = granted && own && !fifo_full;
    assign wr       = valid && ready;
    assign data_out = wr ? data : '0;
endmodule

module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_write_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                                state, state_nxt;
    logic [IDW-1:0]                        grant_nxt, rr_ptr, rr_nxt;
    logic [3:0]                            beat_cnt, beat_nxt;
    logic [NUM_REQ-1:0]                    lane_wr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    lane_data;
    logic                                  own_valid, rotate;
    logic [IDW-1:0]                        pick_base, pick_id;
    logic [NUM_REQ-1:0]                    pick_mask;
    logic                                  pick_any;
    int                                    idx;

    assign grant_valid = (state == GRANT);
    assign own_valid   = req_valid[grant_id];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        fifo_write_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .granted  (grant_valid),
            .own      (grant_id == IDW'(gi)),
            .fifo_full(fifo_full),
            .valid    (req_valid[gi]),
            .data     (req_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .ready    (req_ready[gi]),
            .wr       (lane_wr[gi]),
            .data_out (lane_data[gi])
        );
    end

    // Only the owner lane can be non-zero, so an OR-reduce acts as the data mux.
    always_comb begin
        fifo_data_in = '0;
        for (int i = 0; i < NUM_REQ; i++)
            fifo_data_in = fifo_data_in | lane_data[i];
        fifo_write_en = |lane_wr;
    end

    // Scan base+1 .. base+NUM_REQ; descending loop so the nearest hit wins.
    // In GRANT the base is the current owner, which is masked out of the re-pick.
    always_comb begin
        pick_base = grant_valid ? grant_id : rr_ptr;
        pick_mask = req_valid;
        if (grant_valid)
            pick_mask[grant_id] = 1'b0;
        pick_any = 1'b0;
        pick_id  = '0;
        idx      = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(pick_base) + k) % NUM_REQ;
            if (pick_mask[IDW'(idx)]) begin
                pick_any = 1'b1;
                pick_id  = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        beat_nxt  = beat_cnt;
        rr_nxt    = rr_ptr;
        rotate    = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_nxt = GRANT;
                    grant_nxt = pick_id;
                    beat_nxt  = '0;
                end
            end
            GRANT: begin
                // A full FIFO freezes the grant; the owner resumes when it drains.
                if (!fifo_full) begin
                    rotate = (fifo_write_en && (beat_cnt + 4'd1 == 4'(MAX_BURST))) || !own_valid;
                    if (rotate) begin
                        rr_nxt   = grant_id;
                        beat_nxt = '0;
                        if (pick_any) begin
                            grant_nxt = pick_id;
                        end else begin
                            state_nxt = IDLE;
                            grant_nxt = '0;
                        end
                    end else if (fifo_write_en) begin
                        beat_nxt = beat_cnt + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            grant_id <= '0;
            beat_cnt <= '0;
            rr_ptr   <= IDW'(NUM_REQ - 1);
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            beat_cnt <= beat_nxt;
            rr_ptr   <= rr_nxt;
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: per-requester word lists, a FIFO occupancy
// model, and a scoreboard of expected (owner, word) pairs checked on every write.

module tb_fifo_write_arbiter;
    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int MB  = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              resetN = 1'b1;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic              fifo_write_en;
    logic [DW-1:0]     fifo_data_in;
    logic              grant_valid;
    logic [IDW-1:0]    grant_id;

    fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_write_en(fifo_write_en),
        .fifo_data_in (fifo_data_in),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
    } wr_t;

    wr_t          exp_q[$];
    logic [DW-1:0] src_mem [NR][16];
    int           src_len [NR];
    int           src_pos [NR];
    logic [NR-1:0] en = '0;
    logic         man_full = 1'b0;
    logic         fmodel = 1'b0;
    int           fcnt = 0, rdiv = 0;
    int           errors = 0, checks = 0, wr_cnt = 0, cyc = 0;

    // Requester driver: advance on accepted handshakes, present the next word.
    initial begin
        logic [NR-1:0] acc;
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            if (resetN)
                for (int i = 0; i < NR; i++)
                    if (acc[i]) src_pos[i]++;
            #1;
            for (int i = 0; i < NR; i++) begin
                req_valid[i] = en[i] && (src_pos[i] < src_len[i]);
                req_data[i*DW +: DW] = (src_pos[i] < src_len[i]) ? src_mem[i][src_pos[i]] : '0;
            end
        end
    end

    // 16-deep FIFO occupancy model with a reader draining one word every third cycle.
    initial begin
        logic w;
        fifo_full = 1'b0;
        forever begin
            @(negedge clk);
            w = fifo_write_en;
            @(posedge clk);
            cyc++;
            if (!fmodel) begin
                fcnt = 0;
            end else begin
                if (w && resetN) begin
                    checks++;
                    if (fcnt >= 16) begin
                        errors++;
                        $display("FAIL fifo_overflow: write while occupancy=%0d, limit 16", fcnt);
                    end else begin
                        fcnt++;
                    end
                end
                rdiv++;
                if (rdiv % 3 == 0 && fcnt > 0) fcnt--;
            end
            #2;
            fifo_full = man_full || (fmodel && fcnt >= 16);
        end
    end

    // Scoreboard monitor
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (resetN && fifo_write_en) begin
                wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got id=%0d data=%h, none expected", grant_id, fifo_data_in);
                end else begin
                    e = exp_q.pop_front();
                    if (grant_id !== e.id || fifo_data_in !== e.data) begin
                        errors++;
                        $display("FAIL write_order: got id=%0d data=%h, expected id=%0d data=%h",
                                 grant_id, fifo_data_in, e.id, e.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input int id, input int s0, input int n);
        for (int k = 0; k < n; k++) src_mem[id][k] = {4'(id), 4'(s0 + k)};
        src_pos[id] = 0;
        src_len[id] = n;
    endtask

    task automatic expect_w(input int id, input int s0, input int n);
        wr_t e;
        for (int k = 0; k < n; k++) begin
            e.id   = IDW'(id);
            e.data = {4'(id), 4'(s0 + k)};
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_writes(input int target);
        int t = 0;
        while (wr_cnt < target && t < 300) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (wr_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL wait_writes_timeout: got %0d writes, expected %0d", wr_cnt, target);
        end
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() > 0 && t < 400) begin
            @(negedge clk);
            #1;
            t++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL %s_drain: %0d writes missing, expected 0", name, exp_q.size());
        end
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        resetN   = 1'b0;
        en       = '0;
        man_full = 1'b0;
        fmodel   = 1'b0;
        for (int i = 0; i < NR; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    initial begin
        int base, c0;
        // Reset values
        #2 resetN = 1'b0;
        #1;
        chk("rst_write_en", fifo_write_en, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_grant_id", grant_id, 0);
        do_reset();

        // Asynchronous reset mid-burst, then first grant goes to requester 0
        for (int i = 0; i < NR; i++) load(i, 0, 8);
        expect_w(0, 0, 2);
        en = 4'hF;
        base = wr_cnt;
        wait_writes(base + 2);
        @(posedge clk);
        #1 resetN = 1'b0;
        #1;
        chk("midrst_write_en", fifo_write_en, 0);
        chk("midrst_ready", req_ready, 0);
        chk("midrst_grant_valid", grant_valid, 0);
        chk("midrst_grant_id", grant_id, 0);
        do_reset();
        for (int i = 0; i < NR; i++) load(i, 8, 1);
        for (int i = 0; i < NR; i++) expect_w(i, 8, 1);
        en = 4'hF;
        base = wr_cnt;
        wait_writes(base + 1);
        chk("first_grant_id", grant_id, 0);
        wait_drain("after_reset");

        // Burst lock: 0,0,0,0,2,2,2,2,... with no gap between bursts
        do_reset();
        load(0, 0, 8);
        load(2, 0, 8);
        expect_w(0, 0, 4); expect_w(2, 0, 4); expect_w(0, 4, 4); expect_w(2, 4, 4);
        en = 4'b0101;
        base = wr_cnt;
        wait_writes(base + 1);
        c0 = cyc;
        wait_writes(base + 16);
        chk("burst_no_gap_cycles", cyc - c0, 15);
        wait_drain("burst");

        // Round-robin wrap from rr_ptr=3: 1, then 3, then 1 again
        do_reset();
        load(1, 0, 8);
        load(3, 0, 4);
        expect_w(1, 0, 4); expect_w(3, 0, 4); expect_w(1, 4, 4);
        en = 4'b1010;
        wait_drain("rr_wrap");
        chk("rr_wrap_idle", grant_valid, 0);

        // Full stall at beat 2 of owner 1
        do_reset();
        load(1, 0, 8);
        load(3, 0, 4);
        expect_w(1, 0, 4); expect_w(3, 0, 4); expect_w(1, 4, 4);
        en = 4'b1010;
        base = wr_cnt;
        wait_writes(base + 2);
        @(posedge clk);
        #1 man_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("stall_ready", req_ready, 0);
            chk("stall_write_en", fifo_write_en, 0);
            chk("stall_grant_id", grant_id, 1);
        end
        man_full = 1'b0;
        wait_drain("stall");

        // Owner 0 withdraws after one beat, 3 takes over with a fresh burst
        do_reset();
        load(0, 0, 1);
        load(3, 0, 4);
        expect_w(0, 0, 1); expect_w(3, 0, 4);
        en = 4'b1001;
        base = wr_cnt;
        wait_writes(base + 1);
        @(negedge clk);
        #1;
        chk("withdraw_gap_write_en", fifo_write_en, 0);
        chk("withdraw_gap_grant_id", grant_id, 0);
        @(negedge clk);
        #1;
        chk("withdraw_new_owner", grant_id, 3);
        chk("withdraw_new_write_en", fifo_write_en, 1);
        c0 = cyc;
        wait_writes(base + 5);
        chk("withdraw_full_burst_cycles", cyc - c0, 3);
        wait_drain("withdraw");
        chk("withdraw_end_idle", grant_valid, 0);

        // Lone owner withdraws: back to IDLE
        do_reset();
        load(2, 0, 1);
        expect_w(2, 0, 1);
        en = 4'b0100;
        base = wr_cnt;
        wait_writes(base + 1);
        @(negedge clk);
        #1;
        chk("lone_withdraw_grant_valid", grant_valid, 1);
        chk("lone_withdraw_grant_id", grant_id, 2);
        chk("lone_withdraw_write_en", fifo_write_en, 0);
        @(negedge clk);
        #1;
        chk("lone_idle_grant_valid", grant_valid, 0);
        chk("lone_idle_grant_id", grant_id, 0);

        // Data integrity through a slow-draining 16-deep FIFO
        do_reset();
        for (int i = 0; i < NR; i++) load(i, 0, 8);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) expect_w(i, 4 * r, 4);
        fmodel = 1'b1;
        rdiv   = 0;
        en     = 4'hF;
        base   = wr_cnt;
        wait_drain("integrity");
        chk("integrity_count", wr_cnt - base, 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the write port of one `fifo` instance among NUM_REQ producers using per-requester valid/ready handshakes.
- Grants are round-robin with a bounded burst lock, so one producer can write up to MAX_BURST consecutive words before the arbiter rotates.
- The block drives the FIFO's `write_en` and `data_in` and honours its `full` flag.
- It sits directly in front of the FIFO; the FIFO's read side is untouched.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_WIDTH, 8: word width; must equal the FIFO's FIFO_WIDTH.
- MAX_BURST, 4: maximum accepted beats per grant before forced rotation, 1..15.

Ports:
- clk  input  1  rising-edge clock.
- resetN  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  bit i: requester i has a word.
- req_data  input  NUM_REQ*DATA_WIDTH  requester i's word in bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  bit i: word i is accepted this cycle.
- fifo_full  input  1  connected to the FIFO's `full`.
- fifo_write_en  output  1  connected to the FIFO's `write_en`.
- fifo_data_in  output  DATA_WIDTH  connected to the FIFO's `data_in`.
- grant_valid  output  1  high in the GRANT state.
- grant_id  output  clog2(NUM_REQ)  current owner; 0 when grant_valid=0.

Behaviour:
- Reset is asynchronous on the negedge of resetN and takes effect immediately, including mid-burst:
  - state=IDLE, grant_id=0, beat_cnt=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has priority first.
  - All outputs are 0. req_ready and fifo_write_en drop in the same cycle because they decode from state.
- Registered state: state {IDLE, GRANT}, grant_id, beat_cnt (4 bits), rr_ptr (last owner).
- Combinational outputs:
  - req_ready[i] = (state==GRANT) && (grant_id==i) && !fifo_full.
  - fifo_write_en = req_valid[grant_id] && req_ready[grant_id].
  - fifo_data_in = req_data slice of grant_id when fifo_write_en=1, else 0.
  - A transfer is the cycle where fifo_write_en=1. Latency is zero: the word reaches the FIFO on the same edge it is accepted.
- Winner selection (pick): the first i with req_valid[i]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ, wrapping and ending at rr_ptr itself.
- IDLE:
  - If any req_valid is high, go to GRANT on the next edge with grant_id=pick and beat_cnt=0.
  - This is a 1-cycle arbitration bubble; otherwise stay in IDLE.
- GRANT, on each edge:
  - If a transfer occurred, beat_cnt increments.
  - Rotate when a transfer occurred and beat_cnt+1 == MAX_BURST, or when req_valid[grant_id]=0 in that cycle (owner withdrew).
  - On rotate: rr_ptr <= grant_id.
  - If any other requester is valid, re-pick excluding the old owner, take it with beat_cnt=0 and no bubble. Otherwise go to IDLE.
  - The old owner is reconsidered only through a fresh IDLE arbitration.
- fifo_full high in GRANT:
  - Hold state; beat_cnt does not advance and there is no timeout.
  - The owner keeps its grant across the stall and continues when full clears.
- Other requesters' valid/data are ignored while not owner. Requesters must hold valid and data stable until ready, per the standard handshake.
- At most one FIFO write per cycle. Overflow is impossible because ready is gated by fifo_full in the same cycle.
- Simultaneous MAX_BURST expiry and owner withdrawal are one rotate event, not two.

Test Plan:
- Reset: resetN=0 mid-burst with req_valid=4'b1111 -> within the same cycle fifo_write_en=0, req_ready=0, grant_valid=0. First grant after release goes to requester 0.
- Burst lock: MAX_BURST=4, requesters 0 and 2 continuously valid, fifo_full=0 -> writes follow ids 0,0,0,0,2,2,2,2,0... with no idle cycle between bursts and one bubble only at start.
- Round-robin wrap: rr_ptr=3, requesters 1 and 3 valid -> requester 1 wins; after its burst, 3 wins, then 1 again.
- Full stall: owner 1 at beat_cnt=2, fifo_full=1 for 5 cycles -> req_ready=0, fifo_write_en=0, grant_id stays 1. After full clears, exactly 2 more beats, then rotate.
- Owner withdraws: owner 0 drops valid after 1 beat while 3 is valid -> next cycle grant_id=3, beat_cnt=0. If none is valid -> IDLE.
- Data integrity: 4 requesters each send 8 tagged words (id in upper nibble) into a 16-deep FIFO with a concurrent reader -> every word appears exactly once and per-requester order is preserved.
